div_x400: RTL and testbench



---
 rtl/div_x400_if.sv | 28 ++
 rtl/div_x400.sv | 179 +++++++++++++++++
 tb/tb_div_x400.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/div_x400_if.sv
// Handshake bundle between the x400 summation pipeline and the divider:
// the summed stamp with its strobe going in, quotient/remainder and status coming out.
interface div_x400_if #(
    parameter int DW = 20,
    parameter int QW = 12,
    parameter int RW = 9
);
    logic [DW-1:0] in_sum;
    logic          in_dval;
    logic          clr_ovf;
    logic [QW-1:0] out_int;
    logic [RW-1:0] out_frac;
    logic          out_dval;
    logic          busy;
    logic          ovf;

    // Upstream side: produces sums, consumes results.
    modport master (
        output in_sum, in_dval, clr_ovf,
        input  out_int, out_frac, out_dval, busy, ovf
    );

    // Divider side.
    modport slave (
        input  in_sum, in_dval, clr_ovf,
        output out_int, out_frac, out_dval, busy, ovf
    );
endinterface

// File: rtl/div_x400.sv
// Iterative restoring divider by a constant (8 channels x 50 fine steps = 400).
// One quotient bit per clock, DW iterations per result, with a one-entry
// pending buffer so a new sum can arrive while a division is in flight.
module div_x400 #(
    parameter int DW      = 20,
    parameter int DIVISOR = 400,
    parameter int QW      = 12,
    parameter int RW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    div_x400_if.slave     bus
);
    localparam int            CW       = $clog2(DW);
    localparam logic [RW:0]   DIV_C    = (RW + 1)'(DIVISOR);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t state, state_next;

    // Working registers of the running division.
    logic [DW-1:0] dvd;
    logic [RW:0]   rem;
    logic [DW-1:0] quo;
    logic [CW-1:0] cnt;

    // One-entry pending buffer, independent of the FSM state.
    logic [DW-1:0] pend_data;
    logic          pend_vld;

    logic          ovf_q;
    logic          out_dval_q;
    logic [QW-1:0] out_int_q;
    logic [RW-1:0] out_frac_q;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    logic [RW:0]   t;
    logic          ge;
    logic [RW:0]   rem_step;
    logic [DW-1:0] quo_step;
    logic          last;

    assign t        = {rem[RW-1:0], dvd[DW-1]};
    assign ge       = (t >= DIV_C);
    assign rem_step = ge ? (t - DIV_C) : t;
    assign quo_step = {quo[DW-2:0], ge};
    assign last     = (state == CALC) && (cnt == CNT_LAST);

    // The quotient MSBs above QW are always zero for legal parameters, and the
    // remainder never exceeds DIVISOR-1 after a step, so these bits go nowhere.
    logic quo_unused;
    assign quo_unused = ^{quo[DW-1], quo_step[DW-1:QW], rem[RW]};

    // Control decisions for this edge.
    logic          start;
    logic [DW-1:0] operand;
    logic          pend_load;
    logic          pend_clear;
    logic          drop;

    // Next state, operand selection and pending-buffer control.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next = state;
        start      = 1'b0;
        operand    = bus.in_sum;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_dval) begin
                    start      = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    // The older pending sum goes first; a same-edge strobe
                    // refills the buffer behind it.
                    if (pend_vld) begin
                        start   = 1'b1;
                        operand = pend_data;
                        if (bus.in_dval) begin
                            pend_load = 1'b1;
                        end else begin
                            pend_clear = 1'b1;
                        end
                    end else if (bus.in_dval) begin
                        start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.in_dval) begin
                    if (pend_vld) begin
                        drop = 1'b1;
                    end else begin
                        pend_load = 1'b1;
                    end
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control flags and result outputs; these are visible so they are reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_vld   <= 1'b0;
            ovf_q      <= 1'b0;
            out_dval_q <= 1'b0;
            out_int_q  <= '0;
            out_frac_q <= '0;
        end else begin
            out_dval_q <= last;
            if (last) begin
                out_int_q  <= quo_step[QW-1:0];
                out_frac_q <= rem_step[RW-1:0];
            end
            if (pend_load) begin
                pend_vld <= 1'b1;
            end else if (pend_clear) begin
                pend_vld <= 1'b0;
            end
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Pending data payload, qualified by pend_vld.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers carry no reset; their valid flag or
        // the FSM state decides when their contents mean anything.
        if (pend_load) begin
            pend_data <= bus.in_sum;
        end
    end

    // Division iteration: load on start, otherwise one restoring step per CALC edge.
    always_ff @(posedge clk) begin
        if (start) begin
            dvd <= operand;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            dvd <= {dvd[DW-2:0], 1'b0};
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
        end
    end

    assign bus.out_int  = out_int_q;
    assign bus.out_frac = out_frac_q;
    assign bus.out_dval = out_dval_q;
    assign bus.busy     = (state == CALC);
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_div_x400.sv
// Directed bench for div_x400: reset values, corner quotients, pending-buffer
// behaviour, overflow flag, final-edge capture and mid-division reset.
module tb_div_x400;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    div_x400_if #(.DW(20), .QW(12), .RW(9)) bus ();

    div_x400 #(.DW(20), .DIVISOR(400), .QW(12), .RW(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One in_dval strobe; returns just after the accepting edge.
    task automatic pulse(input logic [19:0] v);
        bus.in_sum  = v;
        bus.in_dval = 1'b1;
        tick();
        bus.in_dval = 1'b0;
    endtask

    // Isolated division with cycle-exact latency and hold checks.
    task automatic run_one(input logic [19:0] v, input int ei, input int ef);
        pulse(v);
        check("busy_after_accept", 32'(bus.busy), 1);
        for (int k = 1; k < 20; k++) begin
            tick();
            check("dval_early", 32'(bus.out_dval), 0);
            check("busy_during", 32'(bus.busy), 1);
        end
        tick();
        check("dval_at_20", 32'(bus.out_dval), 1);
        check("int", 32'(bus.out_int), 32'(ei));
        check("frac", 32'(bus.out_frac), 32'(ef));
        check("busy_after_final", 32'(bus.busy), 0);
        tick();
        check("dval_one_cycle", 32'(bus.out_dval), 0);
        check("int_hold", 32'(bus.out_int), 32'(ei));
        check("frac_hold", 32'(bus.out_frac), 32'(ef));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_sum  = '0;
        bus.in_dval = 1'b0;
        bus.clr_ovf = 1'b0;

        // Reset values.
        rst = 1'b0;
        repeat (3) tick();
        check("rst_int", 32'(bus.out_int), 0);
        check("rst_frac", 32'(bus.out_frac), 0);
        check("rst_dval", 32'(bus.out_dval), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b1;
        tick();

        // Main function and corner values, each isolated.
        run_one(20'd20050, 50, 50);
        run_one(20'd0, 0, 0);
        run_one(20'd399, 0, 399);
        run_one(20'd400, 1, 0);
        run_one(20'hFFFFF, 2621, 175);

        // Second strobe at edge 5 goes to the pending buffer.
        pulse(20'd400);
        repeat (4) tick();
        bus.in_sum = 20'd800; bus.in_dval = 1'b1;
        tick();
        bus.in_dval = 1'b0;
        check("pend_ovf_e5", 32'(bus.ovf), 0);
        repeat (14) tick();
        check("pend_dval_e19", 32'(bus.out_dval), 0);
        tick();
        check("pend_dval_e20", 32'(bus.out_dval), 1);
        check("pend_int_e20", 32'(bus.out_int), 1);
        check("pend_frac_e20", 32'(bus.out_frac), 0);
        check("pend_busy_e20", 32'(bus.busy), 1);
        repeat (19) tick();
        check("pend_dval_e39", 32'(bus.out_dval), 0);
        tick();
        check("pend_dval_e40", 32'(bus.out_dval), 1);
        check("pend_int_e40", 32'(bus.out_int), 2);
        check("pend_frac_e40", 32'(bus.out_frac), 0);
        check("pend_ovf_e40", 32'(bus.ovf), 0);
        tick();
        check("pend_busy_end", 32'(bus.busy), 0);

        // Strobes at edges 5 and 6: the second is dropped and ovf sticks.
        pulse(20'd400);
        repeat (4) tick();
        bus.in_sum = 20'd800; bus.in_dval = 1'b1;
        tick();
        bus.in_sum = 20'd1200;
        tick();
        bus.in_dval = 1'b0;
        tick();
        check("drop_ovf_e7", 32'(bus.ovf), 1);
        repeat (12) tick();
        tick();
        check("drop_dval_e20", 32'(bus.out_dval), 1);
        check("drop_int_e20", 32'(bus.out_int), 1);
        repeat (19) tick();
        tick();
        check("drop_dval_e40", 32'(bus.out_dval), 1);
        check("drop_int_e40", 32'(bus.out_int), 2);
        check("drop_frac_e40", 32'(bus.out_frac), 0);
        tick();
        check("drop_ovf_sticky", 32'(bus.ovf), 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("clr_ovf", 32'(bus.ovf), 0);

        // Strobe on the final edge with an empty buffer: no IDLE gap.
        pulse(20'd400);
        repeat (19) tick();
        bus.in_sum = 20'd1200; bus.in_dval = 1'b1;
        tick();
        bus.in_dval = 1'b0;
        check("fin_dval_e20", 32'(bus.out_dval), 1);
        check("fin_int_e20", 32'(bus.out_int), 1);
        check("fin_busy_e20", 32'(bus.busy), 1);
        repeat (19) tick();
        check("fin_dval_e39", 32'(bus.out_dval), 0);
        tick();
        check("fin_dval_e40", 32'(bus.out_dval), 1);
        check("fin_int_e40", 32'(bus.out_int), 3);
        check("fin_frac_e40", 32'(bus.out_frac), 0);
        tick();
        check("fin_busy_end", 32'(bus.busy), 0);
        check("fin_ovf", 32'(bus.ovf), 0);

        // Reset at edge 10 of a division discards it.
        pulse(20'd20050);
        repeat (9) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mrst_int", 32'(bus.out_int), 0);
        check("mrst_frac", 32'(bus.out_frac), 0);
        check("mrst_dval", 32'(bus.out_dval), 0);
        check("mrst_busy", 32'(bus.busy), 0);
        check("mrst_ovf", 32'(bus.ovf), 0);
        for (int k = 0; k < 25; k++) begin
            tick();
            check("mrst_no_dval", 32'(bus.out_dval), 0);
        end
        run_one(20'd12345, 30, 345);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
